// File: rtl/dmem_lsu_if.sv
// rtl/dmem_lsu_if.sv - request/response and data-memory bus bundle for dmem_lsu
//
// Purpose: groups the CPU request/response handshake and the data-memory port
//   so the LSU and its neighbours connect through one bundle.
// Ports (signals):
//   req_valid/req_ready/req_write/req_size/req_signed/req_addr/req_wdata - CPU request
//   resp_valid/resp_rdata/resp_err                                       - CPU response
//   DMEM_address/DMEM_data_in/DMEM_mem_write/DMEM_mem_read               - to memory
//   DMEM_data_out                                                        - from memory
// Modports: slave = LSU view, master = requester + memory view.
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] DMEM_address;
  logic [31:0] DMEM_data_in;
  logic        DMEM_mem_write;
  logic        DMEM_mem_read;
  logic [31:0] DMEM_data_out;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  DMEM_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output DMEM_address, DMEM_data_in, DMEM_mem_write, DMEM_mem_read
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output DMEM_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  DMEM_address, DMEM_data_in, DMEM_mem_write, DMEM_mem_read
  );
endinterface

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store unit driving a word-addressed data memory
//
// Purpose: accepts one load/store at a time, performs byte/halfword/word
//   accesses with sign/zero extension on loads and read-modify-write on
//   sub-word stores. Misaligned, reserved-size or out-of-range requests
//   complete with resp_err and never touch memory.
// Ports:
//   clk                 clock, all state updates on posedge
//   rst_n               asynchronous active-low reset
//   bus (slave)         request/response handshake and DMEM port
//   perf_loads/stores/errs  16-bit saturating completion counters
// Configuration macro: LSU_PERF_CNT_EN (counters present when defined,
//   otherwise the counter ports are tied to zero).
module dmem_lsu #(
  parameter int unsigned DEPTH_WORDS = 21
) (
  input  logic         clk,
  input  logic         rst_n,
  dmem_lsu_if.slave    bus,
  output logic [15:0]  perf_loads,
  output logic [15:0]  perf_stores,
  output logic [15:0]  perf_errs
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  state_t      state;
  state_t      state_next;

  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic        err_q;
  // Holds store data (merged word after RMW_RD) or the load result.
  logic [31:0] data_q;

  logic        req_err;
  logic        accept;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign accept = (state == IDLE) && bus.req_valid;

  // Request legality, evaluated on the live request while idle.
  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = bus.req_addr[0];
      2'b10:   req_err = (bus.req_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
    if ({2'b00, bus.req_addr[31:2]} >= DEPTH_WORDS) req_err = 1'b1;
  end

  // Little-endian lane extraction and extension of the memory word.
  always_comb begin
    lane_byte = bus.DMEM_data_out[{addr_q[1:0], 3'b000} +: 8];
    lane_half = bus.DMEM_data_out[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_val = {{24{signed_q & lane_byte[7]}}, lane_byte};
      2'b01:   load_val = {{16{signed_q & lane_half[15]}}, lane_half};
      default: load_val = bus.DMEM_data_out;
    endcase
  end

  // Sub-word store lanes overlaid on the word just read.
  always_comb begin
    merged = bus.DMEM_data_out;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
      default: merged = data_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next         = state;
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.resp_err       = 1'b0;
    bus.resp_rdata     = 32'h0;
    bus.DMEM_address   = 32'h0;
    bus.DMEM_data_in   = 32'h0;
    bus.DMEM_mem_write = 1'b0;
    bus.DMEM_mem_read  = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (req_err)                   state_next = RESP;
          else if (!bus.req_write)       state_next = LOAD;
          else if (bus.req_size == 2'b10) state_next = WRITE;
          else                           state_next = RMW_RD;
        end
      end
      LOAD: begin
        bus.DMEM_mem_read = 1'b1;
        bus.DMEM_address  = {2'b00, addr_q[31:2]};
        state_next        = RESP;
      end
      RMW_RD: begin
        bus.DMEM_mem_read = 1'b1;
        bus.DMEM_address  = {2'b00, addr_q[31:2]};
        state_next        = WRITE;
      end
      WRITE: begin
        bus.DMEM_mem_write = 1'b1;
        bus.DMEM_address   = {2'b00, addr_q[31:2]};
        bus.DMEM_data_in   = data_q;
        state_next         = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        // Stores and errors report zero data.
        bus.resp_rdata = (err_q || write_q) ? 32'h0 : data_q;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'h0;
      err_q    <= 1'b0;
      data_q   <= 32'h0;
    end else if (accept) begin
      write_q  <= bus.req_write;
      size_q   <= bus.req_size;
      signed_q <= bus.req_signed;
      addr_q   <= bus.req_addr;
      err_q    <= req_err;
      data_q   <= bus.req_write ? bus.req_wdata : 32'h0;
    end else if (state == LOAD) begin
      data_q   <= load_val;
    end else if (state == RMW_RD) begin
      data_q   <= merged;
    end
  end

`ifdef LSU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_loads  <= 16'h0;
      perf_stores <= 16'h0;
      perf_errs   <= 16'h0;
    end else if (state == RESP) begin
      if (err_q) begin
        if (perf_errs != 16'hFFFF) perf_errs <= perf_errs + 16'd1;
      end else if (write_q) begin
        if (perf_stores != 16'hFFFF) perf_stores <= perf_stores + 16'd1;
      end else begin
        if (perf_loads != 16'hFFFF) perf_loads <= perf_loads + 16'd1;
      end
    end
  end
`else
  assign perf_loads  = 16'h0;
  assign perf_stores = 16'h0;
  assign perf_errs   = 16'h0;
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed self-checking bench for dmem_lsu
//
// Purpose: drives directed load/store requests against a behavioural
//   21-word memory and checks results, latencies, memory traffic, reset
//   behaviour and (with LSU_PERF_CNT_EN) the performance counters.
// Ports: none (top-level bench).
module tb_dmem_lsu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] perf_loads, perf_stores, perf_errs;

  dmem_lsu_if bus();

  dmem_lsu #(.DEPTH_WORDS(21)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .perf_loads(perf_loads),
    .perf_stores(perf_stores),
    .perf_errs(perf_errs)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:20];
  assign bus.DMEM_data_out = (bus.DMEM_address < 32'd21) ? mem[bus.DMEM_address[4:0]] : 32'h0;

  int          n_rd = 0;
  int          n_wr = 0;
  int          n_resp = 0;
  bit          overlap = 1'b0;
  logic [31:0] last_wdata = 32'h0;

  always @(posedge clk) begin
    if (bus.DMEM_mem_write && bus.DMEM_address < 32'd21)
      mem[bus.DMEM_address[4:0]] <= bus.DMEM_data_in;
    if (bus.DMEM_mem_read) n_rd <= n_rd + 1;
    if (bus.DMEM_mem_write) begin
      n_wr <= n_wr + 1;
      last_wdata <= bus.DMEM_data_in;
    end
    if (bus.DMEM_mem_read && bus.DMEM_mem_write) overlap <= 1'b1;
    if (bus.resp_valid) n_resp <= n_resp + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request (waiting for ready), returns cycles from accept edge
  // to resp_valid; a latency of 10 means the response never came.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er);
    int guard;
    guard = 0;
    while (!bus.req_ready && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = bus.resp_rdata;
    er = bus.resp_err;
  endtask

  task automatic run(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int exp_lat, input logic [31:0] exp_rd, input logic exp_er);
    int          lat;
    logic [31:0] rd;
    logic        er;
    do_req(w, sz, sg, a, wd, lat, rd, er);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, {31'h0, er}, {31'h0, exp_er});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_rd, s_wr, s_resp;
    logic [15:0] exp_pl, exp_ps, exp_pe;

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("rst_rdata", bus.resp_rdata, 32'h0);
    chk("rst_err", {31'h0, bus.resp_err}, 32'h0);
    chk("rst_addr", bus.DMEM_address, 32'h0);
    chk("rst_data_in", bus.DMEM_data_in, 32'h0);
    chk("rst_write", {31'h0, bus.DMEM_mem_write}, 32'h0);
    chk("rst_read", {31'h0, bus.DMEM_mem_read}, 32'h0);
    chk("rst_perf", {perf_loads, perf_errs}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Preload and sub-word loads
    run("st_w_0c", 1, 2'b10, 0, 32'h0C, 32'h8899AABB, 2, 32'h0, 0);
    chk("mem3_pre", mem[3], 32'h8899AABB);
    run("ld_bs_0e", 0, 2'b00, 1, 32'h0E, 32'h0, 2, 32'hFFFFFF99, 0);
    run("ld_hu_0c", 0, 2'b01, 0, 32'h0C, 32'h0, 2, 32'h0000AABB, 0);
    run("ld_hs_0e", 0, 2'b01, 1, 32'h0E, 32'h0, 2, 32'hFFFF8899, 0);
    run("ld_w_0c", 0, 2'b10, 0, 32'h0C, 32'h0, 2, 32'h8899AABB, 0);
    run("ld_bu_0f", 0, 2'b00, 0, 32'h0F, 32'h0, 2, 32'h00000088, 0);

    // Sub-word stores: one read then one write of the merged word
    s_rd = n_rd; s_wr = n_wr;
    run("st_b_0d", 1, 2'b00, 0, 32'h0D, 32'h000000A5, 3, 32'h0, 0);
    chk("st_b_reads", n_rd - s_rd, 1);
    chk("st_b_writes", n_wr - s_wr, 1);
    chk("st_b_wdata", last_wdata, 32'h8899A5BB);
    chk("mem3_byte", mem[3], 32'h8899A5BB);
    run("st_h_0e", 1, 2'b01, 0, 32'h0E, 32'hFFFF1234, 3, 32'h0, 0);
    chk("mem3_half", mem[3], 32'h1234A5BB);

    // Errors never touch memory
    s_rd = n_rd; s_wr = n_wr;
    run("err_w_06", 1, 2'b10, 0, 32'h06, 32'h12345678, 1, 32'h0, 1);
    run("err_w_54", 1, 2'b10, 0, 32'h54, 32'h12345678, 1, 32'h0, 1);
    run("err_h_01", 0, 2'b01, 0, 32'h01, 32'h0, 1, 32'h0, 1);
    run("err_sz11", 0, 2'b11, 0, 32'h00, 32'h0, 1, 32'h0, 1);
    chk("err_reads", n_rd - s_rd, 0);
    chk("err_writes", n_wr - s_wr, 0);

    // Last valid word index
    run("st_w_50", 1, 2'b10, 0, 32'h50, 32'hCAFEF00D, 2, 32'h0, 0);
    run("ld_w_50", 0, 2'b10, 0, 32'h50, 32'h0, 2, 32'hCAFEF00D, 0);

    // Reset during WRITE drops the store and its response
    run("st_w_14", 1, 2'b10, 0, 32'h14, 32'h11111111, 2, 32'h0, 0);
    @(posedge clk); #1;
    s_resp = n_resp; s_wr = n_wr;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
    bus.req_signed = 1'b0; bus.req_addr = 32'h14; bus.req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rstmid_write_hi", {31'h0, bus.DMEM_mem_write}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_write_lo", {31'h0, bus.DMEM_mem_write}, 32'h0);
    chk("rstmid_ready", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("rstmid_no_resp", n_resp - s_resp, 0);
    chk("rstmid_no_write", n_wr - s_wr, 0);
    chk("rstmid_mem5", mem[5], 32'h11111111);
    chk("rstmid_ready_rel", {31'h0, bus.req_ready}, 32'h1);

    // Post-reset traffic: 2 loads, 1 store, 1 error
    run("post_ld_w", 0, 2'b10, 0, 32'h0C, 32'h0, 2, 32'h1234A5BB, 0);
    run("post_ld_hs", 0, 2'b01, 1, 32'h0E, 32'h0, 2, 32'h00001234, 0);
    run("post_st_b", 1, 2'b00, 0, 32'h50, 32'h00000011, 3, 32'h0, 0);
    run("post_err", 0, 2'b11, 0, 32'h00, 32'h0, 1, 32'h0, 1);
    @(posedge clk); #1;
    chk("mem20_byte", mem[20], 32'hCAFEF011);
`ifdef LSU_PERF_CNT_EN
    exp_pl = 16'd2; exp_ps = 16'd1; exp_pe = 16'd1;
`else
    exp_pl = 16'd0; exp_ps = 16'd0; exp_pe = 16'd0;
`endif
    chk("perf_loads", {16'h0, perf_loads}, {16'h0, exp_pl});
    chk("perf_stores", {16'h0, perf_stores}, {16'h0, exp_ps});
    chk("perf_errs", {16'h0, perf_errs}, {16'h0, exp_pe});
    chk("rd_wr_overlap", {31'h0, overlap}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
